onehot_step_seq: RTL and testbench

Parametrised timing-step generator for the processor control unit: a step counter that drives a registered one-hot decoder, producing the T0..Tn control strobes. It generalises the fixed 4-to-16 registered decoder in the following ways:
- configurable select and output widths;
- a valid-code limit;
- an enable/clear/load counter in front of the decoder;
- a runtime wrap point;
- wrap or stop-at-end mode.

The control FSM consumes `t` directly.

---
 rtl/onehot_step_pkg.sv | 33 +++
 rtl/onehot_dec.sv | 21 ++
 rtl/onehot_step_seq.sv | 111 +++++++++++
 tb/tb_onehot_step_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/onehot_step_pkg.sv
// onehot_step_pkg
//   Shared types and helpers for the one-hot timing-step generator.
//   - step_mode_e   : end-of-sequence behaviour (wrap to 0 or stop and flag done)
//   - onehot_decode : code -> one-hot vector, all-zero for codes >= valid_codes
//   - params_ok     : parameter legality, used for elaboration-time checks
package onehot_step_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_STOP = 1'b1
   } step_mode_e;

   // Widest select/decode the helpers support; callers slice down to OUT_W.
   localparam int MAX_SEL_W = 8;
   localparam int MAX_OUT_W = 1 << MAX_SEL_W;

   function automatic logic [MAX_OUT_W-1:0] onehot_decode(
      input logic [MAX_SEL_W-1:0] code,
      input int                   valid_codes
   );
      if (int'(code) < valid_codes)
         return {{(MAX_OUT_W-1){1'b0}}, 1'b1} << code;
      else
         return '0;
   endfunction

   function automatic bit params_ok(input int sel_w, input int out_w, input int valid_codes);
      return (sel_w >= 1) && (sel_w <= MAX_SEL_W) &&
             (out_w >= 1) && (out_w <= (1 << sel_w)) &&
             (valid_codes >= 1) && (valid_codes <= out_w);
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec
//   Purely combinational one-hot decoder.
//   code : SEL_W-bit select
//   t    : OUT_W-bit one-hot, bit <code> set when code < VALID_CODES, else zero
module onehot_dec
   import onehot_step_pkg::*;
#(
   parameter int SEL_W       = 4,
   parameter int OUT_W       = 16,
   parameter int VALID_CODES = 10
) (
   input  logic [SEL_W-1:0] code,
   output logic [OUT_W-1:0] t
);

   logic [MAX_SEL_W-1:0] code_x;

   assign code_x = MAX_SEL_W'(code);
   assign t      = OUT_W'(onehot_decode(code_x, VALID_CODES));

endmodule

// File: rtl/onehot_step_seq.sv
// onehot_step_seq
//   Step counter feeding a registered one-hot decoder; produces the T0..Tn
//   control strobes for the control FSM.
//   clock      : rising-edge clock
//   resetn     : asynchronous active-low reset
//   en         : advance one step
//   clr        : restart at step 0 (highest priority)
//   ld/ld_step : load an arbitrary step value (may be out of range)
//   last_step  : runtime final step, clamped to VALID_CODES-1
//   mode       : 0 = wrap at the final step, 1 = stop there and raise done
//   step       : current step (registered)
//   t          : one-hot decode of step, same flop stage as step
//   wrap       : one-cycle pulse when en returned the counter to 0
//   done       : STOP mode reached the final step; cleared only by clr/ld
//   range_err  : step holds a code >= VALID_CODES
module onehot_step_seq
   import onehot_step_pkg::*;
#(
   parameter int SEL_W       = 4,
   parameter int OUT_W       = 16,
   parameter int VALID_CODES = 10
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             en,
   input  logic             clr,
   input  logic             ld,
   input  logic [SEL_W-1:0] ld_step,
   input  logic [SEL_W-1:0] last_step,
   input  logic             mode,
   output logic [SEL_W-1:0] step,
   output logic [OUT_W-1:0] t,
   output logic             wrap,
   output logic             done,
   output logic             range_err
);

   generate
      if (!params_ok(SEL_W, OUT_W, VALID_CODES)) begin : g_bad_params
         $error("onehot_step_seq: illegal SEL_W/OUT_W/VALID_CODES combination");
      end
   endgenerate

   localparam logic [SEL_W-1:0] LAST_VALID = SEL_W'(VALID_CODES - 1);

   logic [SEL_W-1:0] eff_last;
   logic [SEL_W-1:0] step_n;
   logic [OUT_W-1:0] t_n;
   logic             wrap_n;
   logic             done_n;
   logic             range_err_n;

   // last_step is used live every cycle; nothing latches it.
   assign eff_last = (last_step < LAST_VALID) ? last_step : LAST_VALID;

   always_comb begin
      step_n = step;
      done_n = done;
      wrap_n = 1'b0;
      if (clr) begin
         step_n = '0;
         done_n = 1'b0;
      end else if (ld) begin
         step_n = ld_step;
         done_n = 1'b0;
      end else if (en && !done) begin
         // Once done is set, en is ignored regardless of the current mode.
         if (step < eff_last) begin
            step_n = step + SEL_W'(1);
         end else if (step > eff_last) begin
            // Beyond the end (loaded high or last_step lowered): restart.
            step_n = '0;
            wrap_n = 1'b1;
         end else if (step_mode_e'(mode) == MODE_STOP) begin
            done_n = 1'b1;
         end else begin
            step_n = '0;
            wrap_n = 1'b1;
         end
      end
   end

   assign range_err_n = (step_n > LAST_VALID);

   // Decode the next step so t lands in the same flop stage as step.
   onehot_dec #(
      .SEL_W       (SEL_W),
      .OUT_W       (OUT_W),
      .VALID_CODES (VALID_CODES)
   ) u_dec (
      .code (step_n),
      .t    (t_n)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         step      <= '0;
         t         <= OUT_W'(1);
         wrap      <= 1'b0;
         done      <= 1'b0;
         range_err <= 1'b0;
      end else begin
         step      <= step_n;
         t         <= t_n;
         wrap      <= wrap_n;
         done      <= done_n;
         range_err <= range_err_n;
      end
   end

endmodule

// File: tb/tb_onehot_step_seq.sv
module tb_onehot_step_seq;
   localparam int SEL_W = 4;
   localparam int OUT_W = 16;
   localparam int VC    = 10;

   logic             clock = 1'b0;
   logic             resetn = 1'b0;
   logic             en = 1'b0, clr = 1'b0, ld = 1'b0, mode = 1'b0;
   logic [SEL_W-1:0] ld_step = '0, last_step = 4'd9;
   logic [SEL_W-1:0] step;
   logic [OUT_W-1:0] t;
   logic             wrap, done, range_err;

   onehot_step_seq #(.SEL_W(SEL_W), .OUT_W(OUT_W), .VALID_CODES(VC)) dut (
      .clock(clock), .resetn(resetn), .en(en), .clr(clr), .ld(ld),
      .ld_step(ld_step), .last_step(last_step), .mode(mode),
      .step(step), .t(t), .wrap(wrap), .done(done), .range_err(range_err)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: integer step, done flag, wrap flag.
   int m_step;
   bit m_done, m_wrap;
   int m_eff;

   function automatic logic [OUT_W-1:0] exp_t(input int s);
      logic [OUT_W-1:0] r;
      r = '0;
      if (s < VC) r[s] = 1'b1;
      return r;
   endfunction

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_step = 0; m_done = 0; m_wrap = 0;
      end else begin
         m_eff  = (int'(last_step) < VC - 1) ? int'(last_step) : VC - 1;
         m_wrap = 0;
         if (clr) begin
            m_step = 0; m_done = 0;
         end else if (ld) begin
            m_step = int'(ld_step); m_done = 0;
         end else if (en && !m_done) begin
            if (m_step == m_eff && mode) m_done = 1;
            else if (m_step >= m_eff) begin m_step = 0; m_wrap = 1; end
            else m_step = m_step + 1;
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en && resetn) begin
         check("step", 32'(step), 32'(m_step));
         check("t", 32'(t), 32'(exp_t(m_step)));
         check("wrap", 32'(wrap), 32'(m_wrap));
         check("done", 32'(done), 32'(m_done));
         check("range_err", 32'(range_err), 32'(m_step >= VC));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_step"}, 32'(step), 32'd0);
      check({tag, "_t"}, 32'(t), 32'h0001);
      check({tag, "_wrap"}, 32'(wrap), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_rerr"}, 32'(range_err), 32'd0);
   endtask

   int wraps;

   initial begin
      #12;
      check_reset_vals("rst");
      @(negedge clock);
      resetn = 1'b1;
      chk_en = 1;

      // WRAP mode, last_step 9
      mode = 1'b0; last_step = 4'd9; en = 1'b1;
      cyc(9);
      check("wrap9_t", 32'(t), 32'h0200);
      cyc(1);
      check("wrap_t0", 32'(t), 32'h0001);
      check("wrap_pulse", 32'(wrap), 32'd1);
      wraps = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         if (wrap) wraps++;
      end
      check("wrap_count", 32'(wraps), 32'd3);

      // STOP mode, last_step 3
      clr = 1'b1; cyc(1); clr = 1'b0;
      mode = 1'b1; last_step = 4'd3;
      cyc(3);
      check("stop_step3", 32'(step), 32'd3);
      check("stop_t8", 32'(t), 32'h0008);
      check("stop_nodone", 32'(done), 32'd0);
      cyc(1);
      check("stop_done", 32'(done), 32'd1);
      check("stop_hold", 32'(step), 32'd3);
      mode = 1'b0; cyc(2);
      check("done_sticky", 32'(done), 32'd1);
      clr = 1'b1; cyc(1); clr = 1'b0;
      check("clr_t", 32'(t), 32'h0001);
      check("clr_done", 32'(done), 32'd0);

      // load out of range, then en restarts
      mode = 1'b1; en = 1'b0; ld = 1'b1; ld_step = 4'd12; cyc(1); ld = 1'b0;
      check("ld12_step", 32'(step), 32'd12);
      check("ld12_t", 32'(t), 32'h0000);
      check("ld12_rerr", 32'(range_err), 32'd1);
      en = 1'b1; cyc(1);
      check("ld12_en_t", 32'(t), 32'h0001);
      check("ld12_en_wrap", 32'(wrap), 32'd1);
      check("ld12_en_rerr", 32'(range_err), 32'd0);

      // priority
      en = 1'b0; ld = 1'b1; ld_step = 4'd7; cyc(1);
      clr = 1'b1; ld = 1'b1; ld_step = 4'd5; en = 1'b1; cyc(1);
      check("prio_clr", 32'(step), 32'd0);
      clr = 1'b0; cyc(1);
      check("prio_ld", 32'(step), 32'd5);
      ld = 1'b0;

      // clamped last_step, then lowering mid-count
      mode = 1'b0; last_step = 4'd15; clr = 1'b1; cyc(1); clr = 1'b0;
      cyc(9);
      check("clamp_step9", 32'(step), 32'd9);
      cyc(1);
      check("clamp_wrap", 32'(wrap), 32'd1);
      cyc(6);
      last_step = 4'd2; cyc(1);
      check("lower_step", 32'(step), 32'd0);
      check("lower_wrap", 32'(wrap), 32'd1);

      // eff_last 0: wrap stays high
      last_step = 4'd0; cyc(2);
      check("b2b_wrap", 32'(wrap), 32'd1);

      // async reset mid-count with done set
      mode = 1'b1; last_step = 4'd4; clr = 1'b1; cyc(1); clr = 1'b0;
      cyc(5);
      check("pre_rst_done", 32'(done), 32'd1);
      #2 resetn = 1'b0;
      #1 check_reset_vals("async");
      cyc(2);
      resetn = 1'b1; mode = 1'b0; last_step = 4'd9;
      cyc(3);
      check("resume_step", 32'(step), 32'd3);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         en      = ($urandom_range(0, 3) != 0);
         clr     = ($urandom_range(0, 32) == 0);
         ld      = ($urandom_range(0, 19) == 0);
         ld_step = SEL_W'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) last_step = SEL_W'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         cyc(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
